// File: rtl/avalon_mm_to_ahb_lite.sv
// Avalon-MM slave to AHB-Lite master bridge for single transfers, one at a time.
// The Avalon command is captured in IDLE and replayed as an AHB address phase and data phase.
module avalon_mm_to_ahb_lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] avl_address,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [DATA_WIDTH-1:0] avl_writedata,
    output logic                  avl_waitrequest_n,
    output logic [DATA_WIDTH-1:0] avl_readdata,
    output logic                  avl_readdatavalid,
    output logic                  avl_writeresponsevalid,
    output logic [1:0]            avl_response,
    output logic [ADDR_WIDTH-1:0] ahb_haddr,
    output logic                  ahb_hwrite,
    output logic [2:0]            ahb_hsize,
    output logic [2:0]            ahb_hburst,
    output logic                  ahb_hmastlock,
    output logic [3:0]            ahb_hprot,
    output logic [1:0]            ahb_htrans,
    output logic [DATA_WIDTH-1:0] ahb_hwdata,
    input  logic [DATA_WIDTH-1:0] ahb_hrdata,
    input  logic                  ahb_hready,
    input  logic                  ahb_hresp
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
        $error("avalon_mm_to_ahb_lite: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    write_q;
    logic [1:0]              resp_q;
    logic                    cmd;

    assign cmd = avl_read | avl_write;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd)        next_state = ADDR;
            ADDR: if (ahb_hready) next_state = DATA;
            DATA: if (ahb_hready) next_state = RESP;
            RESP:                 next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Captured command and registered completion; these hold between transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            if (state == IDLE && cmd) begin
                addr_q  <= avl_address;
                wdata_q <= avl_writedata;
                write_q <= avl_write;
            end
            if (state == DATA && ahb_hready) begin
                rdata_q <= ahb_hrdata;
                resp_q  <= ahb_hresp ? 2'b10 : 2'b00;
            end
        end
    end

    always_comb begin
        avl_waitrequest_n      = 1'b0;
        ahb_htrans             = 2'b00;
        avl_readdatavalid      = 1'b0;
        avl_writeresponsevalid = 1'b0;
        avl_response           = 2'b00;
        case (state)
            IDLE: avl_waitrequest_n = 1'b1;
            ADDR: ahb_htrans = 2'b10;
            RESP: begin
                avl_readdatavalid      = ~write_q;
                avl_writeresponsevalid = write_q;
                avl_response           = resp_q;
            end
            default: ;
        endcase
    end

    assign avl_readdata  = rdata_q;
    assign ahb_haddr     = addr_q;
    assign ahb_hwrite    = write_q;
    assign ahb_hwdata    = wdata_q;
    assign ahb_hsize     = (DATA_WIDTH == 64) ? 3'b011 : 3'b010;
    assign ahb_hburst    = 3'b000;
    assign ahb_hmastlock = 1'b0;
    assign ahb_hprot     = 4'b0011;

endmodule
